// File: rtl/pipeline_ctrl_stage.sv
// Control-word pipeline for the ID/EX, EX/MEM and MEM/WB stages of a 5-stage MIPS core.
// Handles load-use stalls, branch/jump flushes, global hold and EX-stage forwarding selects.
module pipeline_ctrl_stage #(
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [9:0]      id_ctrl,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic [RA_W-1:0] id_rd,
    input  logic            branch_taken,
    input  logic            hold,
    output logic [9:0]      ex_ctrl,
    output logic [9:0]      mem_ctrl,
    output logic [9:0]      wb_ctrl,
    output logic [RA_W-1:0] ex_rs,
    output logic [RA_W-1:0] ex_rt,
    output logic [RA_W-1:0] ex_wreg,
    output logic [RA_W-1:0] mem_wreg,
    output logic [RA_W-1:0] wb_wreg,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            ifid_flush,
    output logic [1:0]      forward_a,
    output logic [1:0]      forward_b
);

    // Control-word bit positions
    localparam int REG_DST   = 9;
    localparam int REG_WRITE = 6;
    localparam int MEM_READ  = 5;
    localparam int JUMP      = 2;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    logic [9:0]      ex_ctrl_q,  ex_ctrl_d;
    logic [RA_W-1:0] ex_rs_q,    ex_rs_d;
    logic [RA_W-1:0] ex_rt_q,    ex_rt_d;
    logic [RA_W-1:0] ex_rd_q,    ex_rd_d;
    logic [9:0]      mem_ctrl_q;
    logic [RA_W-1:0] mem_wreg_q;
    logic [9:0]      wb_ctrl_q;
    logic [RA_W-1:0] wb_wreg_q;

    logic luse;
    logic bubble;
    logic [RA_W-1:0] ex_wreg_w;

    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] src,
        input logic            mem_we,
        input logic [RA_W-1:0] mem_dst,
        input logic            wb_we,
        input logic [RA_W-1:0] wb_dst
    );
        if (mem_we && mem_dst != '0 && mem_dst == src)
            return FWD_MEM;
        else if (wb_we && wb_dst != '0 && wb_dst == src)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign luse = ex_ctrl_q[MEM_READ] && (ex_rt_q != '0) &&
                  ((ex_rt_q == id_rs) || (ex_rt_q == id_rt));
    // A taken branch discards the ID instruction, so it also squashes EX.
    assign bubble    = luse || branch_taken;
    assign ex_wreg_w = ex_ctrl_q[REG_DST] ? ex_rd_q : ex_rt_q;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        ex_ctrl_d  = id_ctrl;
        ex_rs_d    = id_rs;
        ex_rt_d    = id_rt;
        ex_rd_d    = id_rd;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        if (bubble) begin
            ex_ctrl_d = '0;
            ex_rs_d   = '0;
            ex_rt_d   = '0;
            ex_rd_d   = '0;
        end
        if (!hold) begin
            pc_write   = branch_taken || !luse;
            ifid_write = branch_taken || !luse;
            ifid_flush = branch_taken || (id_ctrl[JUMP] && !luse);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_ctrl_q  <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
            mem_ctrl_q <= '0;
            mem_wreg_q <= '0;
            wb_ctrl_q  <= '0;
            wb_wreg_q  <= '0;
        end else if (!hold) begin
            ex_ctrl_q  <= ex_ctrl_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_rd_q    <= ex_rd_d;
            mem_ctrl_q <= ex_ctrl_q;
            mem_wreg_q <= ex_wreg_w;
            wb_ctrl_q  <= mem_ctrl_q;
            wb_wreg_q  <= mem_wreg_q;
        end
    end

    assign forward_a = fwd_sel(ex_rs_q, mem_ctrl_q[REG_WRITE], mem_wreg_q,
                               wb_ctrl_q[REG_WRITE], wb_wreg_q);
    assign forward_b = fwd_sel(ex_rt_q, mem_ctrl_q[REG_WRITE], mem_wreg_q,
                               wb_ctrl_q[REG_WRITE], wb_wreg_q);

    assign ex_ctrl  = ex_ctrl_q;
    assign mem_ctrl = mem_ctrl_q;
    assign wb_ctrl  = wb_ctrl_q;
    assign ex_rs    = ex_rs_q;
    assign ex_rt    = ex_rt_q;
    assign ex_wreg  = ex_wreg_w;
    assign mem_wreg = mem_wreg_q;
    assign wb_wreg  = wb_wreg_q;

endmodule
